// File: rtl/branch_resolve_stage.sv
// ============================================================================
// Module   : branch_resolve_stage
// Purpose  : Signed-corrected branch/SLT resolution with a valid/ready output
//            register, flush, and a saturating taken-branch counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_resolve_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_gt,
  input  logic             in_eq,
  input  logic             in_lt,
  input  logic             in_a31,
  input  logic             in_b31,
  input  logic [31:0]      in_pc4,
  input  logic [15:0]      in_imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [31:0]      out_target,
  output logic [31:0]      out_set,
  output logic             out_err,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [2:0] c_op_beq  = 3'b000;
  localparam logic [2:0] c_op_bne  = 3'b001;
  localparam logic [2:0] c_op_slt  = 3'b010;
  localparam logic [2:0] c_op_sltu = 3'b011;
  localparam logic [2:0] c_op_blez = 3'b100;
  localparam logic [2:0] c_op_bgtz = 3'b101;
  localparam logic [2:0] c_op_bltz = 3'b110;
  localparam logic [2:0] c_op_bgez = 3'b111;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic        w_capture;
  logic        w_s_gt;
  logic        w_s_eq;
  logic        w_s_lt;
  logic        w_onehot;
  logic        w_is_set;
  logic        w_cond;
  logic        w_taken;
  logic [31:0] w_set;
  logic [31:0] w_target;
  logic        w_count;

  assign out_valid = (r_state == FULL);
  assign in_ready  = !out_valid | out_ready;
  assign w_capture = in_valid & !flush & in_ready;

  // Differing sign bits decide a signed compare regardless of magnitude.
  always_comb begin
    w_s_gt = in_gt;
    w_s_eq = in_eq;
    w_s_lt = in_lt;
    if (in_a31 != in_b31) begin
      w_s_lt = in_a31;
      w_s_gt = in_b31;
      w_s_eq = 1'b0;
    end
  end

  assign w_onehot = (in_gt ^ in_eq ^ in_lt) & !(in_gt & in_eq & in_lt);
  assign w_is_set = (in_op == c_op_slt) | (in_op == c_op_sltu);

  always_comb begin
    w_cond = 1'b0;
    case (in_op)
      c_op_beq:  w_cond = in_eq;
      c_op_bne:  w_cond = !in_eq;
      c_op_slt:  w_cond = w_s_lt;
      c_op_sltu: w_cond = in_lt;
      c_op_blez: w_cond = w_s_lt | in_eq;
      c_op_bgtz: w_cond = w_s_gt;
      c_op_bltz: w_cond = w_s_lt;
      c_op_bgez: w_cond = w_s_gt | in_eq;
      default:   w_cond = 1'b0;
    endcase
  end

  assign w_taken  = w_onehot & !w_is_set & w_cond;
  assign w_set    = {31'd0, w_onehot & w_is_set & w_cond};
  assign w_target = in_pc4 + {{14{in_imm[15]}}, in_imm, 2'b00};

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (in_valid) w_state_nxt = FULL;
        FULL:    if (out_ready && !in_valid) w_state_nxt = EMPTY;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_taken  <= 1'b0;
      out_target <= 32'd0;
      out_set    <= 32'd0;
      out_err    <= 1'b0;
    end else if (w_capture) begin
      out_taken  <= w_taken;
      out_target <= w_target;
      out_set    <= w_set;
      out_err    <= !w_onehot;
    end
  end

  // A flushed transfer is not delivered, so it must not be counted.
  assign w_count = out_valid & out_ready & out_taken & !out_err & !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt <= '0;
    end else if (w_count && (taken_cnt != c_cnt_max)) begin
      taken_cnt <= taken_cnt + c_cnt_one;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_stage.sv
// ============================================================================
// Module   : tb_branch_resolve_stage
// Purpose  : Directed self-checking bench for branch_resolve_stage (CNT_W=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve_stage;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic             in_gt;
  logic             in_eq;
  logic             in_lt;
  logic             in_a31;
  logic             in_b31;
  logic [31:0]      in_pc4;
  logic [15:0]      in_imm;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic [31:0]      out_target;
  logic [31:0]      out_set;
  logic             out_err;
  logic [CNT_W-1:0] taken_cnt;

  int n_cmp;
  int n_err;

  branch_resolve_stage #(.CNT_W(CNT_W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_gt      (in_gt),
    .in_eq      (in_eq),
    .in_lt      (in_lt),
    .in_a31     (in_a31),
    .in_b31     (in_b31),
    .in_pc4     (in_pc4),
    .in_imm     (in_imm),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_taken  (out_taken),
    .out_target (out_target),
    .out_set    (out_set),
    .out_err    (out_err),
    .taken_cnt  (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] flags,
                       input logic a31, input logic b31,
                       input logic [31:0] pc4, input logic [15:0] imm);
    in_valid = 1'b1;
    in_op    = op;
    {in_gt, in_eq, in_lt} = flags;
    in_a31   = a31;
    in_b31   = b31;
    in_pc4   = pc4;
    in_imm   = imm;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic t,
                         input logic [31:0] tgt, input logic [31:0] s, input logic e);
    chk({tag, ".valid"},  {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".taken"},  {31'd0, out_taken}, {31'd0, t});
    chk({tag, ".target"}, out_target, tgt);
    chk({tag, ".set"},    out_set, s);
    chk({tag, ".err"},    {31'd0, out_err}, {31'd0, e});
  endtask

  task automatic chk_reset(input string tag);
    chk_out(tag, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk({tag, ".cnt"},   {30'd0, taken_cnt}, 32'd0);
    chk({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    in_op = 3'b000; {in_gt, in_eq, in_lt} = 3'b010; in_a31 = 1'b0; in_b31 = 1'b0;
    in_pc4 = 32'd0; in_imm = 16'd0;
    step(); step();
    rst = 1'b0;
    chk_reset("rst0");

    // BEQ taken, latency 1, counter after delivery
    drive(3'b000, 3'b010, 1'b0, 1'b0, 32'h0040_0004, 16'h0003);
    step();
    in_valid = 1'b0;
    chk_out("beq", 1'b1, 1'b1, 32'h0040_0010, 32'd0, 1'b0);
    step();
    chk("beq.cnt", {30'd0, taken_cnt}, 32'd1);
    chk("beq.drain", {31'd0, out_valid}, 32'd0);

    // back-to-back stream: SLT, SLTU, BNE wrap, BGEZ, BLEZ, BGTZ
    drive(3'b010, 3'b100, 1'b1, 1'b0, 32'h0000_1000, 16'h0000);
    step();
    chk_out("slt", 1'b1, 1'b0, 32'h0000_1000, 32'd1, 1'b0);
    drive(3'b011, 3'b100, 1'b1, 1'b0, 32'h0000_2000, 16'h0001);
    step();
    chk_out("sltu", 1'b1, 1'b0, 32'h0000_2004, 32'd0, 1'b0);
    drive(3'b001, 3'b100, 1'b0, 1'b0, 32'h0000_0000, 16'hFFFF);
    step();
    chk_out("bne", 1'b1, 1'b1, 32'hFFFF_FFFC, 32'd0, 1'b0);
    chk("sltx.cnt", {30'd0, taken_cnt}, 32'd1);
    drive(3'b111, 3'b010, 1'b0, 1'b0, 32'h0000_0100, 16'hFFFE);
    step();
    chk_out("bgez", 1'b1, 1'b1, 32'h0000_00F8, 32'd0, 1'b0);
    chk("bne.cnt", {30'd0, taken_cnt}, 32'd2);
    drive(3'b100, 3'b100, 1'b0, 1'b0, 32'h0000_0300, 16'h0000);
    step();
    chk_out("blez", 1'b1, 1'b0, 32'h0000_0300, 32'd0, 1'b0);
    chk("bgez.cnt", {30'd0, taken_cnt}, 32'd3);
    drive(3'b101, 3'b100, 1'b0, 1'b0, 32'h0000_0400, 16'h0000);
    step();
    in_valid = 1'b0;
    chk_out("bgtz", 1'b1, 1'b1, 32'h0000_0400, 32'd0, 1'b0);
    step();
    chk("sat4.cnt", {30'd0, taken_cnt}, 32'd3);

    // backpressure: first held 3 cycles, second captured on release
    out_ready = 1'b0;
    drive(3'b000, 3'b010, 1'b0, 1'b0, 32'h0000_0100, 16'h0001);
    step();
    drive(3'b110, 3'b100, 1'b1, 1'b0, 32'h0000_0200, 16'h0002);
    chk("bp.ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("bp.hold", 1'b1, 1'b1, 32'h0000_0104, 32'd0, 1'b0);
      chk("bp.hready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.rel", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk_out("bp.second", 1'b1, 1'b1, 32'h0000_0208, 32'd0, 1'b0);
    step();
    chk("bp.drain", {31'd0, out_valid}, 32'd0);
    chk("sat5.cnt", {30'd0, taken_cnt}, 32'd3);

    // reset while FULL
    out_ready = 1'b0;
    drive(3'b000, 3'b010, 1'b0, 1'b0, 32'h0000_0500, 16'h0000);
    step();
    in_valid = 1'b0;
    chk("rf.full", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("rst1");

    // flush while FULL with incoming valid and out_ready
    drive(3'b000, 3'b010, 1'b0, 1'b0, 32'h0000_0010, 16'h0000);
    step();
    drive(3'b000, 3'b010, 1'b0, 1'b0, 32'h0000_0020, 16'h0000);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("fl.ready", {31'd0, in_ready}, 32'd1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl.valid", {31'd0, out_valid}, 32'd0);
    chk("fl.cnt", {30'd0, taken_cnt}, 32'd0);
    chk("fl.nocap", out_target, 32'h0000_0010);
    step();
    chk("fl.idle", {31'd0, out_valid}, 32'd0);

    // non-one-hot flags
    drive(3'b000, 3'b011, 1'b0, 1'b0, 32'h0000_0040, 16'h0004);
    step();
    chk_out("err011", 1'b1, 1'b0, 32'h0000_0050, 32'd0, 1'b1);
    drive(3'b011, 3'b000, 1'b0, 1'b0, 32'h0000_0060, 16'h0000);
    step();
    in_valid = 1'b0;
    chk_out("err000", 1'b1, 1'b0, 32'h0000_0060, 32'd0, 1'b1);
    step();
    chk("err.cnt", {30'd0, taken_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_resolve_stage.md
# branch_resolve_stage

Registered stage directly downstream of the 32-bit magnitude comparator in the MIPS datapath. It takes the comparator's unsigned gt/eq/lt flags plus the operand sign bits, corrects them for signed compares, and resolves the branch condition or the SLT/SLTU result. It also computes the branch target and holds the result in a valid/ready output register with backpressure and flush. A saturating counter tracks branches taken.

## Interface
Parameters:
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream holds a valid compare.
- in_ready  out  1  stage can accept; equals !out_valid | out_ready.
- in_op  in  3  000 BEQ, 001 BNE, 010 SLT, 011 SLTU, 100 BLEZ, 101 BGTZ, 110 BLTZ, 111 BGEZ.
- in_gt, in_eq, in_lt  in  1 each  unsigned comparator flags (A vs B; B=0 for the zero-compare ops).
- in_a31, in_b31  in  1 each  sign bits of A and B.
- in_pc4  in  32  PC+4 of the instruction.
- in_imm  in  16  branch offset in words.
- flush  in  1  kill held and incoming result.
- out_valid  out  1  result register is valid.
- out_ready  in  1  downstream accepts.
- out_taken  out  1  branch condition true; always 0 for SLT/SLTU.
- out_target  out  32  in_pc4 + (sext(in_imm) << 2), mod 2^32.
- out_set  out  32  32'd1 or 32'd0 for SLT/SLTU; 0 for branch ops.
- out_err  out  1  flags not one-hot.
- taken_cnt  out  CNT_W  taken branches delivered downstream, saturating.

## Operation
- Signed correction: if in_a31 != in_b31 then s_lt = in_a31, s_gt = in_b31, s_eq = 0; else s_* = unsigned flags.
- Conditions: BEQ eq; BNE !eq; SLT s_lt; SLTU in_lt; BLEZ s_lt|eq; BGTZ s_gt; BLTZ s_lt; BGEZ s_gt|eq.
- For branch ops, out_taken gets the condition. For SLT/SLTU, out_set[0] gets the condition, out_set[31:1] = 0, and out_taken = 0.
- out_target is computed for every op. Width: 32-bit add, carry discarded, so wrap-around is legal.
- If {in_gt,in_eq,in_lt} is not exactly one-hot: out_err = 1, out_taken = 0, out_set = 0. The target is still computed.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on in_valid & !flush.
  - FULL→EMPTY on out_ready & !(in_valid & !flush).
  - FULL→FULL reloads on out_ready & in_valid & !flush.
  - Otherwise hold.
- Flush has priority: next cycle out_valid = 0, nothing is captured that cycle, and in_ready behaves normally.
- Payload registers load only on capture. While FULL & !out_ready, all outputs stay stable.
- taken_cnt increments on out_valid & out_ready & out_taken & !out_err & !flush. It holds at 2^CNT_W-1.

## Timing
- Latency 1 cycle: a capture at edge N presents results after edge N.
- Throughput 1 per cycle when out_ready stays high.
- in_ready is combinational from out_ready and out_valid only. No path from in_valid to in_ready.
- Reset values:
  - out_valid 0, out_taken 0, out_target 0, out_set 0, out_err 0, taken_cnt 0.
  - in_ready reads 1 the cycle after reset.
- Reset mid-transfer drops the held result; no handshake completes on a reset cycle.
- flush and out_ready together: the transfer does not count, and out_valid clears.

## Test plan
- BEQ, gt/eq/lt=010, pc4=0x00400004, imm=0x0003, out_ready=1 -> next cycle out_valid=1, out_taken=1, out_target=0x00400010, taken_cnt=1.
- SLT with A=-1 vs B=1 (a31=1, b31=0, unsigned gt=1) -> out_set=1, out_taken=0. Same flags with SLTU -> out_set=0.
- BNE, imm=0xFFFF, pc4=0x00000000 -> out_target=0xFFFFFFFC (wrap). BGEZ with a31=0, eq=1 -> taken=1.
- Backpressure: two valid inputs, out_ready=0 for 3 cycles -> in_ready=0, first result held stable. On out_ready=1 -> first transfers, second captured the same edge, no loss or duplication.
- Flush while FULL with in_valid=1 -> out_valid=0 next cycle, no capture, taken_cnt unchanged. Flags=011 -> out_err=1, out_taken=0.
- CNT_W=2, five taken transfers -> taken_cnt saturates at 3. rst asserted while FULL -> all outputs at reset values next cycle.
